inst_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the pipelined CPU. It owns the PC and drives the word address of the combinational instruction ROM. It captures each returned word together with its PC into a small prefetch buffer and presents it to decode through a valid/ready handshake. It also handles branch redirects (flush plus PC load) and a halt/drain/resume run-control state machine.

---
 rtl/inst_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: PC, prefetch buffer, branch redirect and halt/drain/resume control.
// Optional FETCH_PERF_EN adds saturating capture and stall counters.
module inst_fetch_ctrl #(
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          clrn,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_inst,
  output logic          id_valid,
  output logic [DW-1:0] id_inst,
  output logic [AW-1:0] id_pc,
  input  logic          id_ready,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          halt_req,
  input  logic          resume,
  output logic          halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]   fetch_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]   last_inst_q;
  logic [AW-1:0]   last_pc_q;
  logic [DW-1:0]   inst_mem [DEPTH];
  logic [AW-1:0]   pc_mem   [DEPTH];
  logic            pop, space, capture;

  assign rom_addr = pc_q;
  assign id_valid = (count_q != '0);
  assign pop      = id_valid & id_ready;
  assign space    = (count_q < DEPTH_C) | pop;
  assign capture  = (state_q == FETCH) & space & ~br_taken & ~halt_req;
  assign halted   = (state_q == HALTED);

  // With the buffer empty the outputs show the most recently presented head.
  assign id_inst = id_valid ? inst_mem[rd_ptr_q] : last_inst_q;
  assign id_pc   = id_valid ? pc_mem[rd_ptr_q]   : last_pc_q;

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (br_taken) begin
      pc_d     = br_target;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (capture) begin
        pc_d     = pc_q + AW'(1);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (capture ? ONE_C : '0) - (pop ? ONE_C : '0);
    end
  end

  // A redirect while draining or halted only flushes; it never moves the state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (halt_req) state_d = DRAIN;
      DRAIN:   if (!br_taken && ((count_q == '0) || ((count_q == ONE_C) && pop))) state_d = HALTED;
      HALTED:  if (!br_taken && resume) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      last_inst_q <= '0;
      last_pc_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (id_valid) begin
        last_inst_q <= inst_mem[rd_ptr_q];
        last_pc_q   <= pc_mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      inst_mem[wr_ptr_q] <= rom_inst;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (capture && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (id_valid && !id_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a queue-based fetch model predicts deliveries,
// a negedge monitor compares what the DUT presents.
module tb_inst_fetch_ctrl;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_inst;
  logic          id_valid;
  logic [DW-1:0] id_inst;
  logic [AW-1:0] id_pc;
  logic          id_ready = 1'b0;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic          halt_req = 1'b0;
  logic          resume = 1'b0;
  logic          halted;
`ifdef FETCH_PERF_EN
  logic [15:0]   fetch_cnt, stall_cnt;
`endif

  inst_fetch_ctrl #(.AW(AW), .DW(DW), .DEPTH(2)) dut (
    .clk(clk), .clrn(clrn), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_ready(id_ready),
    .br_taken(br_taken), .br_target(br_target), .halt_req(halt_req),
    .resume(resume), .halted(halted)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM: word k holds 0x1000_0000 + k
  assign rom_inst = 32'h1000_0000 + {26'd0, rom_addr};

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } ent_t;

  ent_t          mbuf[$];
  ent_t          sb[$];
  logic [AW-1:0] mpc;
  int            mstate;          // 0 fetching, 1 draining, 2 halted
  int unsigned   mfetch, mstall;
  logic [DW-1:0] last_inst;
  logic [AW-1:0] last_pc;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of the edge about to happen, using the inputs currently driven.
  task automatic model_update();
    int   n;
    bit   pop, cap;
    ent_t e;
    n   = mbuf.size();
    pop = (n > 0) && id_ready;
    cap = (mstate == 0) && ((n < 2) || pop) && !br_taken && !halt_req;
    if ((n > 0) && !id_ready && (mstall != 65535)) mstall++;
    if (cap && (mfetch != 65535)) mfetch++;
    if (br_taken) begin
      mbuf.delete();
      sb.delete();
      mpc = br_target;
    end else begin
      if (pop) void'(mbuf.pop_front());
      if (cap) begin
        e.pc   = mpc;
        e.inst = 32'h1000_0000 + {26'd0, mpc};
        mbuf.push_back(e);
        sb.push_back(e);
        mpc = mpc + 6'd1;
      end
    end
    case (mstate)
      0: if (halt_req) mstate = 1;
      1: if (!br_taken && ((n == 0) || ((n == 1) && pop))) mstate = 2;
      2: if (!br_taken && resume) mstate = 0;
      default: mstate = 0;
    endcase
  endtask

  always @(negedge clk) begin
    if (clrn === 1'b1) begin
      chk("rom_addr", rom_addr, mpc);
      chk("halted", halted, mstate == 2);
      chk("id_valid", id_valid, sb.size() > 0);
`ifdef FETCH_PERF_EN
      chk("fetch_cnt", fetch_cnt, mfetch);
      chk("stall_cnt", stall_cnt, mstall);
`endif
      if (sb.size() > 0) begin
        chk("id_pc", id_pc, sb[0].pc);
        chk("id_inst", id_inst, sb[0].inst);
        last_inst = sb[0].inst;
        last_pc   = sb[0].pc;
        if (id_ready) begin
          $display("deliver pc=%02h inst=%08h", id_pc, id_inst);
          void'(sb.pop_front());
        end
      end else begin
        chk("hold_inst", id_inst, last_inst);
        chk("hold_pc", id_pc, last_pc);
      end
    end
  end

  task automatic step(input bit r, input bit b, input logic [AW-1:0] t, input bit h, input bit s);
    @(posedge clk);
    #1;
    id_ready  = r;
    br_taken  = b;
    br_target = t;
    halt_req  = h;
    resume    = s;
    @(negedge clk);
    #1;
    model_update();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clrn = 1'b0;
    id_ready = 1'b0; br_taken = 1'b0; br_target = '0; halt_req = 1'b0; resume = 1'b0;
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_inst", id_inst, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_halted", halted, 0);
`ifdef FETCH_PERF_EN
    chk("rst_fetch_cnt", fetch_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    mbuf.delete();
    sb.delete();
    mpc = '0; mstate = 0; mfetch = 0; mstall = 0;
    last_inst = '0; last_pc = '0;
    @(posedge clk);
    #1;
    clrn = 1'b1;
    @(negedge clk);
    #1;
    model_update();
  endtask

  initial begin
    mpc = '0; mstate = 0; mfetch = 0; mstall = 0; last_inst = '0; last_pc = '0;
    // streaming from reset
    do_reset();
    repeat (6) step(1, 0, '0, 0, 0);
    // decode stall fills the buffer, then releases
    do_reset();
    repeat (4) step(0, 0, '0, 0, 0);
    chk("stall_rom_addr", rom_addr, 2);
    chk("stall_id_inst", id_inst, 32'h1000_0000);
    repeat (4) step(1, 0, '0, 0, 0);
    // redirect with a full buffer
    repeat (3) step(0, 0, '0, 0, 0);
    step(0, 1, 6'h20, 0, 0);
    repeat (4) step(1, 0, '0, 0, 0);
    // PC wrap
    step(1, 1, 6'h3E, 0, 0);
    repeat (5) step(1, 0, '0, 0, 0);
    // halt with two entries buffered, then resume
    repeat (3) step(0, 0, '0, 0, 0);
    step(1, 0, '0, 1, 0);
    repeat (4) step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 1);
    repeat (4) step(1, 0, '0, 0, 0);
    // randomized mix of stalls, redirects, halts and resumes
    repeat (1500) step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                       AW'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);
`ifdef FETCH_PERF_EN
    do_reset();
    repeat (65540) step(0, 0, '0, 0, 0);
    chk("stall_sat", stall_cnt, 16'hFFFF);
`endif
    // asynchronous reset while draining with a full buffer
    do_reset();
    repeat (3) step(0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);
    do_reset();
    repeat (4) step(1, 0, '0, 0, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
